ultrasonic_ranger: RTL and testbench
====================================

# ultrasonic_ranger

Multi-channel ultrasonic range controller for HC-SR04-class sensors. It generalises the single-sensor trigger/echo loop to `NUM_CH` sensors, which it fires one at a time in round-robin order. For each sensor it measures echo width in clock cycles, with synchronisation, timeout and saturation. Each result goes out on a one-cycle valid strobe, and a per-channel `near` flag drives LEDs or downstream presence logic.

## Interface
- `NUM_CH`, default 2: number of sensors, at least 1.
- `TRIG_CYCLES`, default 120: trigger pulse length in clk cycles.
- `PERIOD_CYCLES`, default 750000: slot length per channel, measured from trigger start.
- `TIMEOUT_CYCLES`, default 600000: time allowed from trigger end to echo fall. Constraint: `TRIG_CYCLES + TIMEOUT_CYCLES + 4 < PERIOD_CYCLES`.
- `WIDTH_W`, default 20: width of the echo-width counter.
- `HYST_CYCLES`, default 1000: hysteresis band. Used only with `ULTRASONIC_HYST_EN`.
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `echo` in, `NUM_CH`: raw echo lines, asynchronous to `clk`.
- `thresh` in, `WIDTH_W`: near threshold in cycles, sampled when a result is produced.
- `trig` out, `NUM_CH`: trigger outputs.
- `near` out, `NUM_CH`: per-channel presence flag.
- `meas_valid` out, 1: one-cycle result strobe.
- `meas_ch` out, `$clog2(NUM_CH)` (minimum 1): channel of the current result.
- `meas_width` out, `WIDTH_W`: echo high time in cycles.
- `meas_timeout` out, 1: the result is a timeout.

## Operation
- Each `echo` bit passes through a 2-flop synchroniser. All edge detection uses the synchronised value and its previous value.
- FSM states are IDLE, TRIG, WAIT_RISE, MEASURE, HOLD. The FSM handles one channel at a time, indexed by `ch`.
- IDLE: entered from reset. The next cycle goes to TRIG, with the slot counter at 0.
- TRIG: `trig[ch]` is high for exactly `TRIG_CYCLES` cycles, then the FSM goes to WAIT_RISE and the timeout counter clears.
- WAIT_RISE: waits for a synchronised 0→1 edge on `echo[ch]`.
  - An echo that is already high at TRIG exit does not count as a rise.
  - On the rise, the width counter is set to 1 and the FSM goes to MEASURE.
- MEASURE: the width counter increments each cycle while echo is high and saturates at 2^`WIDTH_W`−1. On the synchronised 1→0 edge, the FSM issues a result and goes to HOLD.
- Timeout: in WAIT_RISE or MEASURE, if the timeout counter reaches `TIMEOUT_CYCLES`:
  - issue a result with `meas_timeout`=1 and `meas_width` = 2^`WIDTH_W`−1;
  - go to HOLD.
- HOLD: waits until the slot counter reaches `PERIOD_CYCLES`−1. It then advances `ch` (wrapping from `NUM_CH`−1 to 0) and re-enters TRIG.
- Every slot produces exactly one result.
- Non-active channels: their `echo` inputs are ignored and their `trig` outputs stay low.
- Near rule (macro off): on each result, `near[ch]` = !timeout && width < `thresh`. Other channels' `near` bits hold their values.
- `thresh` = 0 forces `near` to 0.

## Timing
- Reset values: `trig`=0, `near`=0, `meas_valid`=0, `meas_ch`=0, `meas_width`=0, `meas_timeout`=0. The FSM is in IDLE with `ch`=0.
- After `rst_n` rises, `trig[0]` asserts on the 2nd rising clk edge.
- Channel n's trigger rises exactly `PERIOD_CYCLES` cycles after channel n−1's trigger.
- `meas_valid` asserts 3 cycles after the raw echo falling edge (2 synchroniser cycles plus 1 registered-output cycle). The synchroniser delay applies equally to both edges, so `meas_width` equals the raw high time to within ±1 cycle.
- `meas_ch`, `meas_width`, `meas_timeout` and `near` update on the same edge that `meas_valid` asserts, and hold until the next result.
- Reset asserted mid-slot: all outputs clear immediately (asynchronously), and no partial result is issued.
- An echo pulse shorter than 1 cycle may be missed. If it is missed, the slot times out.

## Configuration
- `ULTRASONIC_HYST_EN` defined:
  - `near[ch]` sets when a non-timeout width < `thresh`;
  - it clears on a timeout, or on width ≥ `thresh` + `HYST_CYCLES` (the sum is computed at `WIDTH_W`+1 bits, no wrap);
  - widths in the band between the two leave `near[ch]` unchanged.
- `ULTRASONIC_HYST_EN` undefined: the plain near rule applies and `HYST_CYCLES` is unused.

## Test plan
All tests use `NUM_CH`=2, `TRIG_CYCLES`=4, `PERIOD_CYCLES`=200, `TIMEOUT_CYCLES`=150, `WIDTH_W`=10, `thresh`=50.

- Ch0 echo rises 10 cycles after trigger end and stays high 30 cycles → one `meas_valid` with `meas_ch`=0, `meas_width`=30±1, `meas_timeout`=0, `near[0]`=1.
- Ch1 echo high for 80 cycles → `meas_width`=80±1, `near[1]`=0, `near[0]` unchanged; `trig[1]` rise is exactly 200 cycles after `trig[0]` rise.
- No echo on ch0 → `meas_valid` 150 cycles after trigger end, with `meas_timeout`=1, `meas_width`=1023, `near[0]`=0.
- Echo held high from before the trigger until the end of the slot → timeout result; no rise is accepted.
- `rst_n` pulsed low during MEASURE → `trig`, `near`, `meas_valid` = 0 immediately; no result strobe; after release, ch0 is triggered first.
- With `ULTRASONIC_HYST_EN` and `HYST_CYCLES`=20: width sequence 40, 60, 75 → `near` goes 1, stays 1, then 0.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: round-robin trigger/echo range controller for NUM_CH HC-SR04-class
// sensors. Each slot fires one sensor, measures the synchronised echo width, and issues
// exactly one result (measured or timeout) with a one-cycle meas_valid strobe.
// Optional hysteresis on the near flags: define ULTRASONIC_HYST_EN.
module ultrasonic_ranger #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned TRIG_CYCLES    = 120,
    parameter int unsigned PERIOD_CYCLES  = 750000,
    parameter int unsigned TIMEOUT_CYCLES = 600000,
    parameter int unsigned WIDTH_W        = 20,
    parameter int unsigned HYST_CYCLES    = 1000,
    localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  echo,
    input  logic [WIDTH_W-1:0] thresh,
    output logic [NUM_CH-1:0]  trig,
    output logic [NUM_CH-1:0]  near,
    output logic               meas_valid,
    output logic [CH_W-1:0]    meas_ch,
    output logic [WIDTH_W-1:0] meas_width,
    output logic               meas_timeout
);

    localparam int unsigned SLOT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_CYCLES - 1);
    localparam logic [SLOT_W-1:0] TRIG_END  = SLOT_W'(TRIG_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    // Parameter sanity checks, evaluated at elaboration only.
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("ultrasonic_ranger: NUM_CH must be at least 1");
    end
    if (TRIG_CYCLES + TIMEOUT_CYCLES + 4 >= PERIOD_CYCLES) begin : g_bad_period
        $error("ultrasonic_ranger: slot too short for trigger plus timeout");
    end
    if (HYST_CYCLES >= 2 ** WIDTH_W) begin : g_bad_hyst
        $error("ultrasonic_ranger: HYST_CYCLES must fit in WIDTH_W bits");
    end

    typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StHold} state_t;

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [WIDTH_W-1:0] width;

    logic [NUM_CH-1:0]  echo_meta;
    logic [NUM_CH-1:0]  echo_sync;
    logic [NUM_CH-1:0]  echo_prev;
    logic               echo_rise;
    logic               echo_fall;
    logic               near_meas;

    // Two-flop synchroniser per echo line plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= '0;
            echo_sync <= '0;
            echo_prev <= '0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    // Edges of the active channel only; other channels are ignored.
    always_comb begin
        echo_rise = echo_sync[ch] & ~echo_prev[ch];
        echo_fall = ~echo_sync[ch] & echo_prev[ch];
    end

`ifdef ULTRASONIC_HYST_EN
    logic [WIDTH_W:0] clear_level;

    // Near flag for a measured (non-timeout) result: set below thresh, clear at or above
    // thresh + HYST_CYCLES (no wrap), hold inside the band.
    always_comb begin
        clear_level = {1'b0, thresh} + (WIDTH_W + 1)'(HYST_CYCLES);
        near_meas   = near[ch];
        if (width < thresh) begin
            near_meas = 1'b1;
        end else if ({1'b0, width} >= clear_level) begin
            near_meas = 1'b0;
        end
    end
`else
    // Near flag for a measured (non-timeout) result; thresh of 0 can never be beaten.
    always_comb begin
        near_meas = (width < thresh);
    end
`endif

    // Slot sequencer: trigger, wait for echo, measure, then hold to the end of the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            ch           <= '0;
            slot_cnt     <= '0;
            tmo_cnt      <= '0;
            width        <= '0;
            trig         <= '0;
            near         <= '0;
            meas_valid   <= 1'b0;
            meas_ch      <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state != StIdle) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (state == StWaitRise || state == StMeasure) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            case (state)
                StIdle: begin
                    slot_cnt <= '0;
                    state    <= StTrig;
                end
                StTrig: begin
                    if (slot_cnt == TRIG_END) begin
                        trig    <= '0;
                        tmo_cnt <= '0;
                        state   <= StWaitRise;
                    end else begin
                        trig[ch] <= 1'b1;
                    end
                end
                StWaitRise: begin
                    if (tmo_cnt == TMO_LAST) begin
                        meas_valid   <= 1'b1;
                        meas_ch      <= ch;
                        meas_width   <= '1;
                        meas_timeout <= 1'b1;
                        near[ch]     <= 1'b0;
                        state        <= StHold;
                    end else if (echo_rise) begin
                        width <= WIDTH_W'(1);
                        state <= StMeasure;
                    end
                end
                StMeasure: begin
                    // A fall on the last allowed cycle still counts as a measurement.
                    if (echo_fall) begin
                        meas_valid   <= 1'b1;
                        meas_ch      <= ch;
                        meas_width   <= width;
                        meas_timeout <= 1'b0;
                        near[ch]     <= near_meas;
                        state        <= StHold;
                    end else if (tmo_cnt == TMO_LAST) begin
                        meas_valid   <= 1'b1;
                        meas_ch      <= ch;
                        meas_width   <= '1;
                        meas_timeout <= 1'b1;
                        near[ch]     <= 1'b0;
                        state        <= StHold;
                    end else if (width != '1) begin
                        width <= width + WIDTH_W'(1);
                    end
                end
                StHold: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        ch       <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
                        state    <= StTrig;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger. Echo pulses come from a per-slot table; a slot-level model
// derives trigger timing, result timing/values and near flags from that table, and every
// cycle the DUT outputs are compared against it. Literal checks pin the model.
module tb_ultrasonic_ranger;

    localparam int NUM_CH  = 2;
    localparam int TRIG    = 4;
    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 150;
    localparam int WW      = 10;
    localparam int HYST    = 20;
    localparam int WMAX    = (1 << WW) - 1;
`ifdef ULTRASONIC_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    echo;
    logic [WW-1:0] thresh;
    logic [1:0]    trig;
    logic [1:0]    near;
    logic          meas_valid;
    logic [0:0]    meas_ch;
    logic [WW-1:0] meas_width;
    logic          meas_timeout;

    ultrasonic_ranger #(
        .NUM_CH        (NUM_CH),
        .TRIG_CYCLES   (TRIG),
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT),
        .WIDTH_W       (WW),
        .HYST_CYCLES   (HYST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .echo        (echo),
        .thresh      (thresh),
        .trig        (trig),
        .near        (near),
        .meas_valid  (meas_valid),
        .meas_ch     (meas_ch),
        .meas_width  (meas_width),
        .meas_timeout(meas_timeout)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release.
    int n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Echo pulse on channel ch: raw high from d edges after the slot's trigger end, h cycles.
    typedef struct {
        int ep;
        int slot;
        int ch;
        int d;
        int h;
    } pulse_t;

    pulse_t     pulses[$];
    int         epoch;
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] m_near;
    int         m_ch;
    int         m_w;
    bit         m_tmo;
    bit         m_any;

    function automatic pulse_t mk(input int ep, input int slot, input int ch, input int d,
                                  input int h);
        pulse_t p;
        p.ep = ep; p.slot = slot; p.ch = ch; p.d = d; p.h = h;
        return p;
    endfunction

    // Edge on which slot k's trigger has just dropped.
    function automatic int e0(input int k);
        return PERIOD * k + TRIG + 2;
    endfunction

    function automatic int th_for(input int ep, input int k);
        return (ep == 1 && k == 3) ? 0 : 50;
    endfunction

    // Expected result of slot k: edge it appears on, width, timeout flag.
    task automatic slot_result(input int ep, input int k, output int res, output int w,
                               output bit tmo);
        int e, m, f;
        e = e0(k);
        res = e + TIMEOUT;
        w = WMAX;
        tmo = 1'b1;
        foreach (pulses[i]) begin
            if (pulses[i].ep == ep && pulses[i].slot == k && pulses[i].ch == k % NUM_CH) begin
                m = e + pulses[i].d;
                f = m + pulses[i].h;
                // Rise must be seen after trigger end; fall must be seen within the timeout.
                if (m + 2 > e && f + 2 <= e + TIMEOUT) begin
                    res = f + 2;
                    w = (pulses[i].h > WMAX) ? WMAX : pulses[i].h;
                    tmo = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        cmp_cnt++;
        if (act < exp - tol || act > exp + tol) begin
            err_cnt++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d +/- %0d", name, n, act, exp,
                     tol);
        end
    endtask

    // Per-cycle comparison of all outputs against the slot model.
    task automatic cycle_check();
        int         k, res, w, th;
        bit         tmo, exp_valid;
        logic [1:0] exp_trig;
        if (!rst_n) begin
            m_near = '0; m_ch = 0; m_w = 0; m_tmo = 1'b0; m_any = 1'b0;
            check("rst_trig", int'(trig), 0);
            check("rst_near", int'(near), 0);
            check("rst_meas_valid", int'(meas_valid), 0);
            check("rst_meas_ch", int'(meas_ch), 0);
            check("rst_meas_width", int'(meas_width), 0);
            check("rst_meas_timeout", int'(meas_timeout), 0);
            return;
        end
        exp_trig = '0;
        exp_valid = 1'b0;
        if (n >= 2 && (n - 2) % PERIOD < TRIG) exp_trig[((n - 2) / PERIOD) % NUM_CH] = 1'b1;
        if (n >= 1) begin
            k = (n - 1) / PERIOD;
            slot_result(epoch, k, res, w, tmo);
            if (n == res) begin
                exp_valid = 1'b1;
                m_any = 1'b1;
                m_ch = k % NUM_CH;
                m_w = w;
                m_tmo = tmo;
                th = th_for(epoch, k);
                if (tmo)                            m_near[m_ch] = 1'b0;
                else if (w < th)                    m_near[m_ch] = 1'b1;
                else if (!HYST_ON || w >= th + HYST) m_near[m_ch] = 1'b0;
            end
        end
        check("trig", int'(trig), int'(exp_trig));
        check("meas_valid", int'(meas_valid), int'(exp_valid));
        check("meas_ch", int'(meas_ch), m_ch);
        check("meas_timeout", int'(meas_timeout), int'(m_tmo));
        if (m_tmo || !m_any) check("meas_width", int'(meas_width), m_w);
        else                 check_tol("meas_width", int'(meas_width), m_w, 1);
        check("near", int'(near), int'(m_near));
    endtask

    // Drive raw echo and thresh for the coming edge from the pulse table.
    task automatic drive();
        int         e, m, f;
        logic [1:0] lvl;
        e = n + 1;
        lvl = '0;
        foreach (pulses[i]) begin
            if (pulses[i].ep == epoch) begin
                m = e0(pulses[i].slot) + pulses[i].d;
                f = m + pulses[i].h;
                if (e >= m && e < f) lvl[pulses[i].ch] = 1'b1;
            end
        end
        echo = lvl;
        thresh = WW'(th_for(epoch, (e - 1) / PERIOD));
    endtask

    initial begin
        pulses.push_back(mk(0, 0, 0, 10, 30));   // near0 set
        pulses.push_back(mk(0, 0, 1, 40, 20));   // inactive channel, ignored
        pulses.push_back(mk(0, 1, 1, 10, 80));   // near1 clear
        pulses.push_back(mk(0, 3, 1, 5, 20));    // slot 2: no echo on ch0 -> timeout
        pulses.push_back(mk(0, 4, 0, -16, 210)); // held high across trigger -> timeout
        pulses.push_back(mk(0, 5, 1, 10, 20));
        pulses.push_back(mk(0, 6, 0, 20, 40));   // reset lands mid-measure
        pulses.push_back(mk(1, 0, 0, 10, 40));
        pulses.push_back(mk(1, 1, 1, 10, 30));
        pulses.push_back(mk(1, 2, 0, 10, 60));   // inside hysteresis band
        pulses.push_back(mk(1, 3, 1, 10, 20));   // thresh forced to 0
        pulses.push_back(mk(1, 4, 0, 10, 75));   // above band

        rst_n = 1'b0;
        epoch = 0;
        echo = '0;
        thresh = WW'(50);
        repeat (3) begin
            @(negedge clk);
            cycle_check();
        end
        rst_n = 1'b1;
        drive();

        while (n < 1250) begin
            @(negedge clk);
            cycle_check();
            drive();
            case (n)
                48: begin
                    check("pin_s0_valid", int'(meas_valid), 1);
                    check("pin_s0_ch", int'(meas_ch), 0);
                    check_tol("pin_s0_width", int'(meas_width), 30, 1);
                    check("pin_s0_timeout", int'(meas_timeout), 0);
                    check("pin_s0_near0", int'(near[0]), 1);
                end
                201: check("pin_trig1_before", int'(trig), 0);
                202: check("pin_trig1_rise", int'(trig), 2);
                298: begin
                    check("pin_s1_valid", int'(meas_valid), 1);
                    check("pin_s1_ch", int'(meas_ch), 1);
                    check_tol("pin_s1_width", int'(meas_width), 80, 1);
                    check("pin_s1_near", int'(near), 1);
                end
                556: begin
                    check("pin_s2_valid", int'(meas_valid), 1);
                    check("pin_s2_timeout", int'(meas_timeout), 1);
                    check("pin_s2_width", int'(meas_width), 1023);
                    check("pin_s2_near0", int'(near[0]), 0);
                end
                956: begin
                    check("pin_held_valid", int'(meas_valid), 1);
                    check("pin_held_timeout", int'(meas_timeout), 1);
                    check("pin_held_ch", int'(meas_ch), 0);
                end
                1038: check("pin_s5_near", int'(near), 2);
                default: ;
            endcase
        end

        // Reset in the middle of slot 6's measurement; outputs clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        check("pin_async_near", int'(near), 0);
        check("pin_async_trig", int'(trig), 0);
        check("pin_async_valid", int'(meas_valid), 0);
        epoch = 1;
        repeat (3) begin
            @(negedge clk);
            cycle_check();
            drive();
        end
        rst_n = 1'b1;
        drive();

        while (n < 1010) begin
            @(negedge clk);
            cycle_check();
            drive();
            case (n)
                1: check("pin_e1_trig_e1", int'(trig), 0);
                2: check("pin_e1_trig_e2", int'(trig), 1);
                58: begin
                    check("pin_e1s0_near0", int'(near[0]), 1);
                    check_tol("pin_e1s0_width", int'(meas_width), 40, 1);
                end
                248: check("pin_e1s1_near", int'(near), 3);
                478: begin
                    check("pin_e1s2_near0", int'(near[0]), int'(HYST_ON));
                    check_tol("pin_e1s2_width", int'(meas_width), 60, 1);
                end
                638: check("pin_e1s3_near1", int'(near[1]), 0);
                893: begin
                    check("pin_e1s4_near0", int'(near[0]), 0);
                    check_tol("pin_e1s4_width", int'(meas_width), 75, 1);
                end
                default: ;
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
